pc_gen_unit: RTL and testbench

Parametrised program-counter generator for the pipeline fetch stage. It holds the PC register and arbitrates the next PC among trap entry, exception return (EPC), JALR, branch/JAL and sequential increment. It supports fetch stalls and latches any redirect that arrives during a stall so the redirect is never lost. It also flags misaligned redirect targets and drives a one-cycle flush pulse to upstream stages.

---
 rtl/pc_gen_pkg.sv | 28 ++
 rtl/pc_gen_unit_if.sv | 43 ++++
 rtl/pc_redirect_arb.sv | 45 ++++
 rtl/pc_gen_unit.sv | 130 +++++++++++++
 tb/tb_pc_gen_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
// PC_COMPRESSED_EN selects 2-byte alignment and +2 sequential steps.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  typedef enum logic {
    CTRL    = 1'b0,
    TRAPCLS = 1'b1
  } redir_cls_e;

  localparam int unsigned PC_INC4 = 4;
  localparam int unsigned PC_INC2 = 2;

  // Low target bits that make a ctrl redirect illegal for the fetch granule.
  function automatic logic target_misaligned(input logic [1:0] lsb);
`ifdef PC_COMPRESSED_EN
    return lsb[0];
`else
    return |lsb;
`endif
  endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch/execute-side bundle of the PC generator; the unit attaches as slave.
// PC_COMPRESSED_EN adds is_compressed_i.
interface pc_gen_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            stall_i;
  logic            br_taken_i;
  logic            is_jal_i;
  logic            is_jalr_i;
  logic [XLEN-1:0] target_i;
  logic            trap_taken_i;
  logic [XLEN-1:0] trap_vec_i;
  logic            epc_taken_i;
  logic [XLEN-1:0] epc_i;
`ifdef PC_COMPRESSED_EN
  logic            is_compressed_i;
`endif
  logic [XLEN-1:0] pc_o;
  logic            pc_valid_o;
  logic            redirect_o;
  logic            misalign_o;
  logic [XLEN-1:0] misalign_addr_o;

  modport master (
    output stall_i, br_taken_i, is_jal_i, is_jalr_i, target_i,
           trap_taken_i, trap_vec_i, epc_taken_i, epc_i,
`ifdef PC_COMPRESSED_EN
    output is_compressed_i,
`endif
    input  pc_o, pc_valid_o, redirect_o, misalign_o, misalign_addr_o
  );

  modport slave (
    input  stall_i, br_taken_i, is_jal_i, is_jalr_i, target_i,
           trap_taken_i, trap_vec_i, epc_taken_i, epc_i,
`ifdef PC_COMPRESSED_EN
    input  is_compressed_i,
`endif
    output pc_o, pc_valid_o, redirect_o, misalign_o, misalign_addr_o
  );

endinterface

// File: rtl/pc_redirect_arb.sv
// Combinational priority select among trap, epc, jalr and branch/jal redirects.
// A misaligned ctrl target is flagged and not presented as a valid request.
module pc_redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            trap_taken_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            epc_taken_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            is_jalr_i,
  input  logic            br_taken_i,
  input  logic            is_jal_i,
  input  logic [XLEN-1:0] target_i,
  output logic            req_c,
  output logic [XLEN-1:0] eff_c,
  output redir_cls_e      cls_c,
  output logic            misalign_c
);

  always_comb begin
    req_c      = 1'b0;
    eff_c      = target_i;
    cls_c      = CTRL;
    misalign_c = 1'b0;
    if (trap_taken_i) begin
      req_c = 1'b1;
      eff_c = trap_vec_i;
      cls_c = TRAPCLS;
    end else if (epc_taken_i) begin
      req_c = 1'b1;
      eff_c = epc_i;
      cls_c = TRAPCLS;
    end else if (is_jalr_i) begin
      eff_c      = {target_i[XLEN-1:1], 1'b0};
      misalign_c = target_misaligned(eff_c[1:0]);
      req_c      = ~misalign_c;
    end else if (br_taken_i || is_jal_i) begin
      misalign_c = target_misaligned(eff_c[1:0]);
      req_c      = ~misalign_c;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC register with redirect arbitration, stall-time redirect latching and
// flush/misalign pulses. PC_COMPRESSED_EN enables +2 steps and 2-byte alignment.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000)
) (
  input logic          clk,
  input logic          rst,
  pc_gen_unit_if.slave bus
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  redir_cls_e      pend_cls_q, pend_cls_d;

  logic            req_c;
  logic [XLEN-1:0] eff_c;
  redir_cls_e      cls_c;
  logic            misalign_c;
  logic [XLEN-1:0] inc_c;

  pc_redirect_arb #(.XLEN(XLEN)) u_arb (
    .trap_taken_i (bus.trap_taken_i),
    .trap_vec_i   (bus.trap_vec_i),
    .epc_taken_i  (bus.epc_taken_i),
    .epc_i        (bus.epc_i),
    .is_jalr_i    (bus.is_jalr_i),
    .br_taken_i   (bus.br_taken_i),
    .is_jal_i     (bus.is_jal_i),
    .target_i     (bus.target_i),
    .req_c        (req_c),
    .eff_c        (eff_c),
    .cls_c        (cls_c),
    .misalign_c   (misalign_c)
  );

`ifdef PC_COMPRESSED_EN
  assign inc_c = bus.is_compressed_i ? XLEN'(PC_INC2) : XLEN'(PC_INC4);
`else
  assign inc_c = XLEN'(PC_INC4);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= BOOT;
      pc_q            <= RESET_VECTOR;
      pc_valid_q      <= 1'b0;
      redirect_q      <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
      pend_tgt_q      <= '0;
      pend_cls_q      <= CTRL;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pc_valid_q      <= pc_valid_d;
      redirect_q      <= redirect_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
      pend_tgt_q      <= pend_tgt_d;
      pend_cls_q      <= pend_cls_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pc_valid_d      = pc_valid_q;
    redirect_d      = 1'b0;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    pend_tgt_d      = pend_tgt_q;
    pend_cls_d      = pend_cls_q;

    // Redirect inputs are meaningless until the first real fetch.
    if ((state_q != BOOT) && misalign_c) begin
      misalign_d      = 1'b1;
      misalign_addr_d = eff_c;
    end

    case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (!bus.stall_i) begin
          if (req_c) begin
            pc_d       = eff_c;
            redirect_d = 1'b1;
          end else begin
            pc_d = pc_q + inc_c;
          end
        end else if (req_c) begin
          pend_tgt_d = eff_c;
          pend_cls_d = cls_c;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (bus.stall_i) begin
          // A latched trap/epc is never displaced by a younger ctrl redirect.
          if (req_c && ((cls_c == TRAPCLS) || (pend_cls_q == CTRL))) begin
            pend_tgt_d = eff_c;
            pend_cls_d = cls_c;
          end
        end else begin
          pc_d       = (req_c && (cls_c == TRAPCLS)) ? eff_c : pend_tgt_q;
          redirect_d = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.pc_o            = pc_q;
  assign bus.pc_valid_o      = pc_valid_q;
  assign bus.redirect_o      = redirect_q;
  assign bus.misalign_o      = misalign_q;
  assign bus.misalign_addr_o = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scenario bench for pc_gen_unit: expected outputs queued per driven cycle.
module tb_pc_gen_unit;
  import pc_gen_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RV = 32'h0000_0000;

  localparam logic [2:0] K_NONE = 3'd0;
  localparam logic [2:0] K_BR   = 3'd1;
  localparam logic [2:0] K_JAL  = 3'd2;
  localparam logic [2:0] K_JALR = 3'd3;
  localparam logic [2:0] K_TRAP = 3'd4;
  localparam logic [2:0] K_EPC  = 3'd5;
  localparam logic [2:0] K_TE   = 3'd6;
  localparam logic [2:0] K_TJ   = 3'd7;

  typedef logic [2*XLEN+2:0] obs_t;

  typedef struct packed {
    logic            stall;
    logic [2:0]      kind;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] e_pc;
    logic            e_r;
    logic            e_m;
    logic [XLEN-1:0] e_ma;
  } row_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];
  obs_t got, want;
  logic [XLEN-1:0] ma_hold;

  pc_gen_unit_if #(.XLEN(XLEN)) bus ();

  pc_gen_unit #(.XLEN(XLEN), .RESET_VECTOR(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(input logic stall, input logic [2:0] kind,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [XLEN-1:0] e_pc, input logic e_r,
                              input logic e_m, input logic [XLEN-1:0] e_ma);
    row_t r;
    r.stall = stall; r.kind = kind; r.a = a; r.b = b;
    r.e_pc = e_pc; r.e_r = e_r; r.e_m = e_m; r.e_ma = e_ma;
    return r;
  endfunction

  function automatic obs_t snap();
    return {bus.pc_o, bus.redirect_o, bus.pc_valid_o, bus.misalign_o, bus.misalign_addr_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input row_t r);
    bus.stall_i      = r.stall;
    bus.br_taken_i   = (r.kind == K_BR);
    bus.is_jal_i     = (r.kind == K_JAL);
    bus.is_jalr_i    = (r.kind == K_JALR) || (r.kind == K_TJ);
    bus.trap_taken_i = (r.kind == K_TRAP) || (r.kind == K_TE) || (r.kind == K_TJ);
    bus.epc_taken_i  = (r.kind == K_EPC) || (r.kind == K_TE);
    bus.target_i     = (r.kind == K_TJ) ? r.b : r.a;
    bus.trap_vec_i   = r.a;
    bus.epc_i        = (r.kind == K_TE) ? r.b : r.a;
`ifdef PC_COMPRESSED_EN
    bus.is_compressed_i = 1'b0;
`endif
  endtask

  task automatic test_reset();
    row_t t[$];
    rst = 1'b1;
    ma_hold = '0;
    drive(mk(0, K_NONE, 0, 0, 0, 0, 0, 0));
    sb.push_back({RV, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    got = snap(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_state: got %h want %h", got, want); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) t.push_back(mk(0, K_NONE, 0, 0, RV + 32'(4 * k), 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      if (t[i].e_m) ma_hold = t[i].e_ma;
      sb.push_back({t[i].e_pc, t[i].e_r, 1'b1, t[i].e_m, ma_hold});
      tick();
      got = snap(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL boot_seq[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_branch();
    row_t t[$];
    t.push_back(mk(0, K_BR,   32'h100, 0, 32'h100, 1, 0, 0));
    t.push_back(mk(0, K_BR,   32'h200, 0, 32'h200, 1, 0, 0));
    t.push_back(mk(0, K_NONE, 0,       0, 32'h204, 0, 0, 0));
    t.push_back(mk(0, K_NONE, 0,       0, 32'h208, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      if (t[i].e_m) ma_hold = t[i].e_ma;
      sb.push_back({t[i].e_pc, t[i].e_r, 1'b1, t[i].e_m, ma_hold});
      tick();
      got = snap(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL branch[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_stall();
    row_t t[$];
    t.push_back(mk(1, K_JAL,  32'h300, 0, 32'h208, 0, 0, 0));
    t.push_back(mk(1, K_TRAP, 32'h080, 0, 32'h208, 0, 0, 0));
    t.push_back(mk(1, K_NONE, 0,       0, 32'h208, 0, 0, 0));
    t.push_back(mk(0, K_NONE, 0,       0, 32'h080, 1, 0, 0));
    t.push_back(mk(0, K_NONE, 0,       0, 32'h084, 0, 0, 0));
    t.push_back(mk(1, K_TRAP, 32'h0C0, 0, 32'h084, 0, 0, 0));
    t.push_back(mk(1, K_JAL,  32'h300, 0, 32'h084, 0, 0, 0));
    t.push_back(mk(0, K_NONE, 0,       0, 32'h0C0, 1, 0, 0));
    t.push_back(mk(1, K_BR,   32'h300, 0, 32'h0C0, 0, 0, 0));
    t.push_back(mk(0, K_EPC,  32'h900, 0, 32'h900, 1, 0, 0));
    t.push_back(mk(0, K_NONE, 0,       0, 32'h904, 0, 0, 0));
    t.push_back(mk(1, K_NONE, 0,       0, 32'h904, 0, 0, 0));
    t.push_back(mk(0, K_NONE, 0,       0, 32'h908, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      if (t[i].e_m) ma_hold = t[i].e_ma;
      sb.push_back({t[i].e_pc, t[i].e_r, 1'b1, t[i].e_m, ma_hold});
      tick();
      got = snap(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL stall[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_misalign();
    row_t t[$];
    t.push_back(mk(0, K_JALR, 32'h401, 0, 32'h400, 1, 0, 0));
`ifdef PC_COMPRESSED_EN
    t.push_back(mk(0, K_BR,   32'h502, 0, 32'h502, 1, 0, 0));
    t.push_back(mk(0, K_NONE, 0,       0, 32'h506, 0, 0, 0));
    t.push_back(mk(0, K_JALR, 32'h403, 0, 32'h402, 1, 0, 0));
    t.push_back(mk(1, K_BR,   32'h301, 0, 32'h402, 0, 1, 32'h301));
    t.push_back(mk(0, K_NONE, 0,       0, 32'h406, 0, 0, 0));
`else
    t.push_back(mk(0, K_BR,   32'h502, 0, 32'h404, 0, 1, 32'h502));
    t.push_back(mk(0, K_NONE, 0,       0, 32'h408, 0, 0, 0));
    t.push_back(mk(0, K_JALR, 32'h403, 0, 32'h40C, 0, 1, 32'h402));
    t.push_back(mk(1, K_BR,   32'h301, 0, 32'h40C, 0, 1, 32'h301));
    t.push_back(mk(0, K_NONE, 0,       0, 32'h410, 0, 0, 0));
`endif
    foreach (t[i]) begin
      drive(t[i]);
      if (t[i].e_m) ma_hold = t[i].e_ma;
      sb.push_back({t[i].e_pc, t[i].e_r, 1'b1, t[i].e_m, ma_hold});
      tick();
      got = snap(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL misalign[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_priority_wrap();
    row_t t[$];
    t.push_back(mk(0, K_TE,   32'h080,      32'h900, 32'h080,      1, 0, 0));
    t.push_back(mk(0, K_EPC,  32'h900,      0,       32'h900,      1, 0, 0));
    t.push_back(mk(0, K_TJ,   32'h040,      32'h600, 32'h040,      1, 0, 0));
    t.push_back(mk(0, K_NONE, 0,            0,       32'h044,      0, 0, 0));
    t.push_back(mk(0, K_BR,   32'hFFFFFFFC, 0,       32'hFFFFFFFC, 1, 0, 0));
    t.push_back(mk(0, K_NONE, 0,            0,       32'h000,      0, 0, 0));
    t.push_back(mk(0, K_NONE, 0,            0,       32'h004,      0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      if (t[i].e_m) ma_hold = t[i].e_ma;
      sb.push_back({t[i].e_pc, t[i].e_r, 1'b1, t[i].e_m, ma_hold});
      tick();
      got = snap(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL prio_wrap[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_back_to_back();
    row_t t[$];
    t.push_back(mk(0, K_BR,   32'h1000, 0, 32'h1000, 1, 0, 0));
    t.push_back(mk(0, K_JAL,  32'h2000, 0, 32'h2000, 1, 0, 0));
    t.push_back(mk(0, K_JALR, 32'h3001, 0, 32'h3000, 1, 0, 0));
    t.push_back(mk(0, K_NONE, 0,        0, 32'h3004, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      if (t[i].e_m) ma_hold = t[i].e_ma;
      sb.push_back({t[i].e_pc, t[i].e_r, 1'b1, t[i].e_m, ma_hold});
      tick();
      got = snap(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL b2b[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_reset_pend();
    row_t t[$];
    t.push_back(mk(1, K_JAL,  32'h300, 0, 32'h3004, 0, 0, 0));
    t.push_back(mk(1, K_NONE, 0,       0, 32'h3004, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back({t[i].e_pc, t[i].e_r, 1'b1, t[i].e_m, ma_hold});
      tick();
      got = snap(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pend_setup[%0d]: got %h want %h", i, got, want); end
    end
    drive(mk(0, K_NONE, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    ma_hold = '0;
    sb.push_back({RV, 1'b0, 1'b0, 1'b0, 32'h0});
    #1;
    got = snap(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL async_rst: got %h want %h", got, want); end
    tick();
    rst = 1'b0;
    t.delete();
    for (int k = 0; k < 3; k++) t.push_back(mk(0, K_NONE, 0, 0, RV + 32'(4 * k), 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back({t[i].e_pc, t[i].e_r, 1'b1, t[i].e_m, ma_hold});
      tick();
      got = snap(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL post_rst[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall();
    test_misalign();
    test_priority_wrap();
    test_back_to_back();
    test_reset_pend();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
